apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Single-outstanding APB3 initiator: takes one read/write command on a valid/ready request port, runs the APB SETUP/ACCESS phases, and returns PRDATA/PSLVERR on a valid/ready response port.
- Used to drive the user-plugin APB peripherals from a non-APB source, e.g. a debug bridge or a test sequencer.
- Includes an access-phase timeout and misaligned-address rejection.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr_i.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when high together with req_valid_i.
- req_addr_i  in  APB_ADDR_WIDTH  byte address.
- req_wdata_i  in  32  write data.
- req_write_i  in  1  1=write, 0=read.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  PSLVERR, timeout or misalignment.
- rsp_timeout_o  out  1  error cause was timeout.
- busy_o  out  1  state != IDLE.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Clock and reset: HRESETn is an asynchronous, active-low reset; HCLK is the clock. Assertion forces state IDLE immediately, including mid-transfer.
- Reset values: PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0, busy_o=0, req_ready_o=1. No aborted transfer produces a response.
- req_ready_o = (state==IDLE), combinational from state only, with no dependency on req_valid_i.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req_valid_i & req_ready_o, register addr, wdata and write.
  - If req_addr_i[1:0]!=0: go to RESP with rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0. No APB activity.
  - Otherwise: load PADDR, PWDATA and PWRITE, go to SETUP.
- SETUP (one cycle): PSEL=1, PENABLE=0. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWDATA/PWRITE are held stable throughout.
  - Cycle counter n starts at 1 on the first ACCESS cycle.
  - If PREADY=1: capture rsp_rdata_o = PWRITE ? 0 : PRDATA; rsp_err_o = PSLVERR; rsp_timeout_o = 0; go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and n==TIMEOUT_CYCLES: abort; rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; go to RESP.
  - Else: n++.
  - PREADY takes priority over timeout in the same cycle.
- RESP: PSEL=0, PENABLE=0. rsp_valid_o=1 with rsp_* held stable until rsp_ready_i=1, then go to IDLE. rsp_valid_o never drops without the handshake.
- Idle bus values: PADDR/PWDATA/PWRITE keep their last values when PSEL=0, so there is no toggling.
- Latency: request accepted at edge T, PSEL rises after T, PENABLE after T+1. If PREADY=1 in the first ACCESS cycle, rsp_valid_o is high after T+2. Earliest next acceptance is the cycle after the response handshake. Throughput is at most 1 transfer per 4 cycles.
- PSLVERR and PRDATA are sampled only when PSEL & PENABLE & PREADY.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It is cleared on entry to SETUP.

Test Plan:
- Write 0x000 data 0x000000A5, slave PREADY=1 -> PSEL high 1 cycle before PENABLE, PWRITE=1, PWDATA=0xA5 stable; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Write 0x000=0xA5, write 0x004=0x5A, then read 0x008 from a slave returning A|B -> rsp_rdata=0x000000FF, rsp_err=0.
- Read 0x010 with PREADY held low 3 ACCESS cycles and PSLVERR=1 on the ready cycle; TIMEOUT_CYCLES=8 -> PADDR, PSEL and PENABLE stable 4 ACCESS cycles; rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT_CYCLES=4, PREADY never asserted -> exactly 4 ACCESS cycles, then PSEL=0; rsp_err=1, rsp_timeout=1. Repeat with PREADY=1 on cycle 4 -> normal completion, rsp_timeout=0.
- Request addr 0x006 -> no PSEL pulse; rsp_err=1, rsp_rdata=0. With rsp_ready_i low 5 cycles, rsp_valid and data held and req_ready_o=0 throughout.
- Assert HRESETn low during ACCESS -> PSEL, PENABLE and rsp_valid drop immediately; after release req_ready_o=1 and a new read of 0x000 completes normally.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Bundles the command request/response handshake and the APB3 bus of apb_cmd_master.
// The master modport is the initiator's view. The slave modport is the command-source and peripheral side.
interface apb_cmd_master_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
) ();
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]               req_wdata_i;
    logic                      req_write_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [31:0]               rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      rsp_timeout_o;
    logic                      busy_o;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator driven by a valid/ready command port.
// It adds an ACCESS-phase timeout and rejects misaligned addresses.
module apb_cmd_master #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic              HCLK,
    input logic              HRESETn,
    apb_cmd_master_if.master bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0]         pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]         rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_to_q, rsp_to_d;
    logic                      busy_q, busy_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    // State and every registered output; reset aborts any transfer without a response
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next state and next registered outputs; the address and data regs hold between transfers
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    if (bus.req_addr_i[1:0] != 2'b00) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_to_d    = 1'b0;
                    end else begin
                        state_d  = SETUP;
                        paddr_d  = bus.req_addr_i;
                        pwdata_d = bus.req_wdata_i;
                        pwrite_d = bus.req_write_i;
                        psel_d   = 1'b1;
                        cnt_d    = '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = CNT_W'(1);
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_to_d    = 1'b0;
                end else if (TO_EN && (cnt_q == TO_LIMIT)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.req_ready_o   = (state_q == IDLE);
    assign bus.PADDR         = paddr_q;
    assign bus.PWDATA        = pwdata_q;
    assign bus.PWRITE        = pwrite_q;
    assign bus.PSEL          = psel_q;
    assign bus.PENABLE       = penable_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.rsp_timeout_o = rsp_to_q;
    assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master. A queue scoreboard is checked by a response monitor, and a
// small APB slave model has a configurable number of wait states and an error flag.
module tb_apb_cmd_master;
    localparam int unsigned AW = 12;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic slv_rst_n = 1'b0;

    apb_cmd_master_if #(.APB_ADDR_WIDTH(AW)) bus ();

    apb_cmd_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) u_dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_chk = 0;
    int n_pass = 0;
    logic [33:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // APB slave model: PREADY after slv_wait low ACCESS cycles; 0x008 returns word0|word1
    int          slv_wait = 0;
    logic        slv_never = 1'b0;
    logic        slv_err = 1'b0;
    int          acc_n;
    logic [31:0] mem[16];

    always_comb begin
        bus.PREADY  = bus.PSEL && bus.PENABLE && !slv_never && (acc_n >= slv_wait);
        bus.PSLVERR = bus.PREADY && slv_err;
        bus.PRDATA  = (bus.PADDR == 12'h008) ? (mem[0] | mem[1]) : mem[bus.PADDR[5:2]];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) acc_n <= 0;
        else if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_n <= acc_n + 1;
        else acc_n <= 0;
    end

    always_ff @(posedge HCLK or negedge slv_rst_n) begin
        if (!slv_rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) begin
            mem[bus.PADDR[5:2]] <= bus.PWDATA;
        end
    end

    // Response monitor: every handshake pops one expected {rdata, err, timeout}
    always @(negedge HCLK) begin
        if (HRESETn && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(bus.rsp_valid_o), 64'(0));
            end else begin
                chk("rsp", 64'({bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o}), 64'(sb.pop_front()));
            end
        end
    end

    // Issue one command and observe the bus cycle by cycle; cycle 1 is the first negedge after accept
    task automatic run(input logic [AW-1:0] a, input logic [31:0] wd, input logic wr,
                       input int hold, input logic [33:0] exp,
                       output int lat, output int nacc, output int psel_cyc,
                       output int pen_cyc, output int bad);
        int k;
        int hcnt;
        bit done;
        logic [33:0] held;
        lat = 0; nacc = 0; psel_cyc = 0; pen_cyc = 0; bad = 0; hcnt = 0; done = 0; held = '0;
        @(posedge HCLK); #1;
        bus.req_addr_i  = a;
        bus.req_wdata_i = wd;
        bus.req_write_i = wr;
        bus.req_valid_i = 1'b1;
        bus.rsp_ready_i = (hold == 0);
        sb.push_back(exp);
        k = 0;
        while (!bus.req_ready_o && k < 50) begin
            @(posedge HCLK); #1;
            k++;
        end
        if (k == 50) begin
            chk("accept_timeout", 64'(bus.req_ready_o), 64'(1));
            void'(sb.pop_back());
            bus.req_valid_i = 1'b0;
            return;
        end
        @(posedge HCLK); #1;
        bus.req_valid_i = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge HCLK);
            if (bus.PSEL && psel_cyc == 0) psel_cyc = cyc;
            if (bus.PENABLE && pen_cyc == 0) pen_cyc = cyc;
            if (bus.PSEL && (bus.PADDR != a || bus.PWDATA != wd || bus.PWRITE != wr)) bad++;
            if (bus.PSEL && bus.PENABLE) nacc++;
            if (bus.rsp_valid_o) begin
                if (lat == 0) begin
                    lat  = cyc;
                    held = {bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o};
                end else if ({bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o} != held) begin
                    bad++;
                end
                if (bus.req_ready_o || bus.PSEL) bad++;
                if (bus.rsp_ready_i) done = 1;
                else begin
                    hcnt++;
                    if (hcnt >= hold) begin
                        @(posedge HCLK); #1;
                        bus.rsp_ready_i = 1'b1;
                    end
                end
            end
        end
        if (!done) begin
            chk("rsp_timeout", 64'(bus.rsp_valid_o), 64'(1));
            void'(sb.pop_back());
        end
        @(posedge HCLK); #1;
        bus.rsp_ready_i = 1'b1;
    endtask

    int lat, nacc, pc, ec, bad;

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_write_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_vals", 64'({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA, bus.PWRITE,
                               bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o,
                               bus.rsp_timeout_o, bus.busy_o, bus.req_ready_o}), 64'(1));
        HRESETn = 1'b1;
        slv_rst_n = 1'b1;

        // Zero-wait write: SETUP in cycle 1, ACCESS in cycle 2, response in cycle 3
        run(12'h000, 32'h0000_00A5, 1'b1, 0, {32'h0, 1'b0, 1'b0}, lat, nacc, pc, ec, bad);
        chk("w0_psel_cyc", 64'(pc), 64'(1));
        chk("w0_pen_cyc", 64'(ec), 64'(2));
        chk("w0_lat", 64'(lat), 64'(3));
        chk("w0_nacc", 64'(nacc), 64'(1));
        chk("w0_stable", 64'(bad), 64'(0));

        run(12'h004, 32'h0000_005A, 1'b1, 0, {32'h0, 1'b0, 1'b0}, lat, nacc, pc, ec, bad);
        run(12'h008, 32'h0, 1'b0, 0, {32'h0000_00FF, 1'b0, 1'b0}, lat, nacc, pc, ec, bad);
        chk("r8_lat", 64'(lat), 64'(3));

        // Three wait states and then PSLVERR on the ready cycle
        @(posedge HCLK); #1; slv_wait = 3; slv_err = 1'b1;
        run(12'h010, 32'h0, 1'b0, 0, {32'h0, 1'b1, 1'b0}, lat, nacc, pc, ec, bad);
        chk("slverr_nacc", 64'(nacc), 64'(4));
        chk("slverr_lat", 64'(lat), 64'(6));
        chk("slverr_stable", 64'(bad), 64'(0));

        // The slave never answers: abort after exactly 4 ACCESS cycles
        @(posedge HCLK); #1; slv_err = 1'b0; slv_never = 1'b1;
        run(12'h010, 32'h0, 1'b0, 0, {32'h0, 1'b1, 1'b1}, lat, nacc, pc, ec, bad);
        chk("to_nacc", 64'(nacc), 64'(4));
        chk("to_lat", 64'(lat), 64'(6));
        chk("to_stable", 64'(bad), 64'(0));

        // PREADY in the 4th ACCESS cycle wins over the timeout
        @(posedge HCLK); #1; slv_never = 1'b0;
        run(12'h004, 32'h0, 1'b0, 0, {32'h0000_005A, 1'b0, 1'b0}, lat, nacc, pc, ec, bad);
        chk("edge_nacc", 64'(nacc), 64'(4));

        // Misaligned write with a stalled response consumer
        @(posedge HCLK); #1; slv_wait = 0;
        run(12'h006, 32'h1234_5678, 1'b1, 5, {32'h0, 1'b1, 1'b0}, lat, nacc, pc, ec, bad);
        chk("mis_no_psel", 64'(pc), 64'(0));
        chk("mis_lat", 64'(lat), 64'(1));
        chk("mis_held", 64'(bad), 64'(0));

        // Reset during ACCESS: the transfer vanishes with no response
        @(posedge HCLK); #1;
        slv_never = 1'b1;
        bus.req_addr_i = 12'h000; bus.req_write_i = 1'b0; bus.req_valid_i = 1'b1;
        @(posedge HCLK); #1;
        bus.req_valid_i = 1'b0;
        begin
            int k;
            k = 0;
            while (!bus.PENABLE && k < 20) begin
                @(negedge HCLK);
                k++;
            end
            chk("rst_reached_access", 64'(bus.PENABLE), 64'(1));
        end
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_async", 64'({bus.PSEL, bus.PENABLE, bus.rsp_valid_o, bus.req_ready_o}), 64'(1));
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        slv_never = 1'b0;
        chk("rst_ready", 64'(bus.req_ready_o), 64'(1));
        run(12'h000, 32'h0, 1'b0, 0, {32'h0000_00A5, 1'b0, 1'b0}, lat, nacc, pc, ec, bad);
        chk("post_rst_lat", 64'(lat), 64'(3));

        repeat (3) @(posedge HCLK);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1);
    end
endmodule
